// File: rtl/dsp_pkg.sv
// dsp_pkg: shared state encoding, accumulator sizing and window-length check for the dsp_blocks filters
package dsp_pkg;
  localparam logic ST_FILL = 1'b0;
  localparam logic ST_RUN = 1'b1;
  localparam int LOG2_LEN_MIN = 1;
  localparam int LOG2_LEN_MAX = 6;
  function automatic int acc_width(input int data_width, input int log2_len);
    return data_width + log2_len;
  endfunction
  function automatic bit log2_len_ok(input int log2_len);
    return log2_len >= LOG2_LEN_MIN && log2_len <= LOG2_LEN_MAX;
  endfunction
endpackage

// File: rtl/delay_line.sv
// delay_line: DATA_WIDTH x DEPTH shift register; data_out is the oldest sample (clk, rst active-low sync, en, data_in)
module delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] sr_q, sr_d;
  always_comb sr_d = en ? {sr_q[DEPTH-2:0], data_in} : sr_q;
  always_ff @(posedge clk)
    if (!rst) sr_q <= '0;
    else sr_q <= sr_d;
  assign data_out = sr_q[DEPTH-1];
endmodule

// File: rtl/moving_average.sv
// moving_average: boxcar average of the last 2^LOG2_LEN accepted samples, one output per accept
// ports: clk, rst (sync active-low), en/data_in (sample strobe), data_valid/data_out (one-cycle result)
// MOVING_AVERAGE_ROUNDING_EN selects round-half-up instead of truncation
module moving_average
  import dsp_pkg::*;
#(
  parameter ARCHITECTURE = "BEHAVIORAL",
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_LEN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data_out
);
  localparam int LEN = 1 << LOG2_LEN;
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, LOG2_LEN);
  localparam int CW = LOG2_LEN + 1;
  if (!log2_len_ok(LOG2_LEN) || ARCHITECTURE != "BEHAVIORAL") begin : g_bad_cfg
    $error("moving_average: unsupported configuration");
  end
  logic [ACC_WIDTH-1:0] acc_q, acc_d, next_acc;
  logic [CW-1:0] fill_q, fill_d;
  logic state_q, state_d;
  logic valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d, avg, oldest;
  logic last_fill;
  delay_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(LEN)) u_delay_line (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .data_out(oldest)
  );
  // oldest reads 0 while filling because the delay line is cleared on reset
  assign next_acc = acc_q + ACC_WIDTH'(data_in) - ACC_WIDTH'(oldest);
`ifdef MOVING_AVERAGE_ROUNDING_EN
  logic [ACC_WIDTH:0] rnd;
  assign rnd = {1'b0, next_acc} + (ACC_WIDTH+1)'(LEN / 2);
  assign avg = DATA_WIDTH'(rnd >> LOG2_LEN);
`else
  assign avg = DATA_WIDTH'(next_acc >> LOG2_LEN);
`endif
  assign last_fill = fill_q == CW'(LEN - 1);
  always_ff @(posedge clk)
    if (!rst) begin
      acc_q <= '0;
      fill_q <= '0;
      state_q <= ST_FILL;
      valid_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      acc_q <= acc_d;
      fill_q <= fill_d;
      state_q <= state_d;
      valid_q <= valid_d;
      data_out_q <= data_out_d;
    end
  always_comb begin
    state_d = (state_q == ST_FILL && en && last_fill) ? ST_RUN : state_q;
    fill_d = (state_q == ST_FILL && en) ? fill_q + CW'(1) : fill_q;
    acc_d = en ? next_acc : acc_q;
  end
  // the final filling accept already has a full window, so it produces the first pulse
  always_comb begin
    valid_d = en && (state_q == ST_RUN || last_fill);
    data_out_d = en ? avg : data_out_q;
  end
  assign data_valid = valid_q;
  assign data_out = data_out_q;
endmodule

// File: tb/tb_moving_average.sv
// tb_moving_average: scoreboard bench for moving_average against a sliding-window reference model
module tb_moving_average;
  localparam int DW = 8;
  localparam int L2 = 3;
  localparam int LEN = 1 << L2;
  typedef struct { logic valid; int dout; } exp_t;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic data_valid;
  logic [DW-1:0] data_out;
  int checks = 0, failures = 0;
  exp_t sb[$];
  int win[$];
  int model_dout = 0;
  moving_average #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(DW), .LOG2_LEN(L2)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .data_valid(data_valid), .data_out(data_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int window_avg();
    int s = 0;
    foreach (win[i]) s += win[i];
`ifdef MOVING_AVERAGE_ROUNDING_EN
    return (s + LEN / 2) / LEN;
`else
    return s / LEN;
`endif
  endfunction
  task automatic step(input logic r, input logic e, input int d);
    exp_t x;
    rst = r;
    en = e;
    data_in = DW'(d);
    x.valid = 1'b0;
    if (!r) begin
      win.delete();
      model_dout = 0;
    end else if (e) begin
      win.push_back(d);
      if (win.size() > LEN) void'(win.pop_front());
      model_dout = window_avg();
      x.valid = win.size() == LEN;
    end
    x.dout = model_dout;
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("data_valid", int'(data_valid), int'(x.valid));
        check("data_out", int'(data_out), x.dout);
      end
    end
  end
  initial begin : driver
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 77);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 100);
    step(1'b1, 1'b0, 5);
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, i);
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 255);
    check("acc_peak", int'(dut.acc_q), 2040);
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 40; i++) step(1'b1, logic'(i % 2 == 0), i / 2);
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 200 + i);
    step(1'b0, 1'b1, 9);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 10 * i);
    for (int i = 0; i < 400; i++)
      step(logic'($urandom_range(49) != 0), logic'($urandom_range(9) < 7), int'($urandom_range(255)));
    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
